bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared system bus, N masters. Grants one master at a time.

---
 rtl/bus_pkg.sv | 6 +
 rtl/rr_priority_pick.sv | 24 ++
 rtl/bus_arbiter_rr.sv | 99 +++++++++
 tb/tb_bus_arbiter_rr.sv | 124 ++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: arbiter state encoding and bus-wide parameter defaults
package bus_pkg;
  typedef enum logic {IDLE, OWN} arb_state_e;
  localparam int NUM_MASTERS_DEF = 4;
  localparam int HOLD_MAX_DEF = 16;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: round-robin pick, search starts just after the last owner
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] winner
);
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  int start;
  int off;
  always_comb begin
    start = (int'(last) + 1) % N;
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    off = 0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? i : off;
    valid = |req;
    winner = W'((start + off) % N);
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter holding the grant for a whole transaction
// Define ARB_TIMEOUT_EN to force release of a master that owns the bus for HOLD_MAX cycles.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  localparam int MSEL_W = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] breq,
  input  logic                   bdone,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [MSEL_W-1:0]      msel,
  output logic                   bus_busy,
  output logic                   timeout
);
  arb_state_e state_q, state_d;
  logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
  logic [MSEL_W-1:0] msel_q, msel_d, last_q, last_d, win;
  logic win_valid, release_own;
  rr_priority_pick #(.N(NUM_MASTERS), .W(MSEL_W)) u_pick (
    .req(breq),
    .last(last_q),
    .valid(win_valid),
    .winner(win)
  );
  assign release_own = bdone | ~breq[msel_q];
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, expired;
  assign expired = cnt_q == CW'(HOLD_MAX - 1);
  always_comb begin
    state_d = state_q;
    bgrant_d = bgrant_q;
    msel_d = msel_q;
    last_d = last_q;
    cnt_d = cnt_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = win_valid ? OWN : IDLE;
      bgrant_d = win_valid ? NUM_MASTERS'(1) << win : '0;
      msel_d = win_valid ? win : msel_q;
      last_d = win_valid ? win : last_q;
      cnt_d = '0;
    end else begin
      state_d = (release_own | expired) ? IDLE : OWN;
      bgrant_d = (release_own | expired) ? '0 : bgrant_q;
      timeout_d = ~release_own & expired;
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  always_comb begin
    state_d = state_q;
    bgrant_d = bgrant_q;
    msel_d = msel_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      state_d = win_valid ? OWN : IDLE;
      bgrant_d = win_valid ? NUM_MASTERS'(1) << win : '0;
      msel_d = win_valid ? win : msel_q;
      last_d = win_valid ? win : last_q;
    end else begin
      state_d = release_own ? IDLE : OWN;
      bgrant_d = release_own ? '0 : bgrant_q;
    end
  end
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      bgrant_q <= '0;
      msel_q <= '0;
      last_q <= MSEL_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      bgrant_q <= bgrant_d;
      msel_q <= msel_d;
      last_q <= last_d;
    end
  end
  assign bgrant = bgrant_q;
  assign msel = msel_q;
  assign bus_busy = state_q == OWN;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed vector table plus hand-written hold-limit sequence
module tb_bus_arbiter_rr;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] breq = '0;
  logic bdone = 1'b0;
  logic [3:0] bgrant;
  logic [1:0] msel;
  logic bus_busy, timeout;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic       r;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [1:0] m;
    logic       busy;
  } vec_t;
  vec_t vecs[$];
  bus_arbiter_rr #(.NUM_MASTERS(4), .HOLD_MAX(8)) dut (
    .clk(clk),
    .rstn(rstn),
    .breq(breq),
    .bdone(bdone),
    .bgrant(bgrant),
    .msel(msel),
    .bus_busy(bus_busy),
    .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [3:0] req, input logic done);
    rstn = r;
    breq = req;
    bdone = done;
    @(posedge clk);
    #1;
  endtask
  task automatic v(input logic r, input logic [3:0] req, input logic done,
                   input logic [3:0] g, input logic [1:0] m, input logic busy);
    vecs.push_back('{r, req, done, g, m, busy});
  endtask
  initial begin
    v(0, 4'b1111, 0, 4'b0000, 0, 0);
    v(0, 4'b1111, 0, 4'b0000, 0, 0);
    v(1, 4'b0100, 0, 4'b0100, 2, 1);
    v(1, 4'b0100, 0, 4'b0100, 2, 1);
    v(1, 4'b0100, 0, 4'b0100, 2, 1);
    v(1, 4'b0100, 0, 4'b0100, 2, 1);
    v(1, 4'b0100, 1, 4'b0000, 2, 0);
    v(1, 4'b0000, 0, 4'b0000, 2, 0);
    v(0, 4'b0000, 0, 4'b0000, 0, 0);
    v(1, 4'b1111, 0, 4'b0001, 0, 1);
    v(1, 4'b1111, 0, 4'b0001, 0, 1);
    v(1, 4'b1111, 1, 4'b0000, 0, 0);
    v(1, 4'b1111, 0, 4'b0010, 1, 1);
    v(1, 4'b1111, 0, 4'b0010, 1, 1);
    v(1, 4'b1111, 1, 4'b0000, 1, 0);
    v(1, 4'b1111, 0, 4'b0100, 2, 1);
    v(1, 4'b1111, 0, 4'b0100, 2, 1);
    v(1, 4'b1111, 1, 4'b0000, 2, 0);
    v(1, 4'b1111, 0, 4'b1000, 3, 1);
    v(1, 4'b1111, 0, 4'b1000, 3, 1);
    v(1, 4'b1111, 1, 4'b0000, 3, 0);
    v(1, 4'b1111, 0, 4'b0001, 0, 1);
    v(1, 4'b1111, 0, 4'b0001, 0, 1);
    v(1, 4'b1111, 1, 4'b0000, 0, 0);
    v(1, 4'b0010, 0, 4'b0010, 1, 1);
    v(1, 4'b0010, 0, 4'b0010, 1, 1);
    v(1, 4'b0000, 0, 4'b0000, 1, 0);
    v(1, 4'b0000, 0, 4'b0000, 1, 0);
    v(1, 4'b0000, 1, 4'b0000, 1, 0);
    v(1, 4'b0001, 0, 4'b0001, 0, 1);
    v(1, 4'b1111, 0, 4'b0001, 0, 1);
    v(1, 4'b1110, 1, 4'b0000, 0, 0);
    v(1, 4'b1110, 0, 4'b0010, 1, 1);
    v(1, 4'b0000, 0, 4'b0000, 1, 0);
    v(1, 4'b1000, 0, 4'b1000, 3, 1);
    v(1, 4'b1000, 0, 4'b1000, 3, 1);
    v(0, 4'b1000, 0, 4'b0000, 0, 0);
    v(1, 4'b1001, 0, 4'b0001, 0, 1);
    v(1, 4'b0000, 0, 4'b0000, 0, 0);
    v(1, 4'b0001, 0, 4'b0001, 0, 1);
    v(1, 4'b0000, 0, 4'b0000, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].req, vecs[i].done);
      chk($sformatf("v%0d bgrant", i), 32'(bgrant), 32'(vecs[i].g));
      chk($sformatf("v%0d msel", i), 32'(msel), 32'(vecs[i].m));
      chk($sformatf("v%0d bus_busy", i), 32'(bus_busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d timeout", i), 32'(timeout), 32'd0);
    end
    step(0, 4'b0000, 0);
    for (int c = 1; c <= 8; c++) begin
      step(1, 4'b0011, 0);
      chk($sformatf("hold c%0d bgrant", c), 32'(bgrant), 32'b0001);
      chk($sformatf("hold c%0d timeout", c), 32'(timeout), 32'd0);
    end
`ifdef ARB_TIMEOUT_EN
    step(1, 4'b0011, 0);
    chk("forced bgrant", 32'(bgrant), 32'd0);
    chk("forced timeout", 32'(timeout), 32'd1);
    chk("forced bus_busy", 32'(bus_busy), 32'd0);
    step(1, 4'b0011, 0);
    chk("after bgrant", 32'(bgrant), 32'b0010);
    chk("after msel", 32'(msel), 32'd1);
    chk("after timeout", 32'(timeout), 32'd0);
`else
    for (int c = 9; c <= 12; c++) begin
      step(1, 4'b0011, 0);
      chk($sformatf("unbounded c%0d bgrant", c), 32'(bgrant), 32'b0001);
      chk($sformatf("unbounded c%0d timeout", c), 32'(timeout), 32'd0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
